// File: rtl/imm_extend_pipe.sv
// Immediate sign/zero extender with optional word shift, buffered in a 2-entry FIFO
// that carries an instruction tag alongside each result.
module imm_extend_pipe #(
   parameter int unsigned IN_WIDTH  = 26,
   parameter int unsigned OUT_WIDTH = 64,
   parameter int unsigned TAG_WIDTH = 6
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [IN_WIDTH-1:0]  value_in,
   input  logic [1:0]           field_sel,
   input  logic                 zero_ext,
   input  logic                 shift2,
   input  logic [TAG_WIDTH-1:0] tag_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [OUT_WIDTH-1:0] extended_out,
   output logic [TAG_WIDTH-1:0] tag_out
);

   localparam logic [OUT_WIDTH-1:0] AllOnes  = {OUT_WIDTH{1'b1}};
   localparam logic [OUT_WIDTH-1:0] MaskFull = AllOnes >> (OUT_WIDTH - IN_WIDTH);
   localparam logic [OUT_WIDTH-1:0] Mask19   = AllOnes >> (OUT_WIDTH - 19);
   localparam logic [OUT_WIDTH-1:0] Mask12   = AllOnes >> (OUT_WIDTH - 12);
   localparam logic [OUT_WIDTH-1:0] Mask9    = AllOnes >> (OUT_WIDTH - 9);

   logic [OUT_WIDTH-1:0] padded;
   logic [OUT_WIDTH-1:0] keep_mask;
   logic [OUT_WIDTH-1:0] extended;
   logic [OUT_WIDTH-1:0] result;
   logic                 sign_bit;
   logic                 fill;

   always_comb begin
      padded    = OUT_WIDTH'(value_in);
      keep_mask = MaskFull;
      sign_bit  = value_in[IN_WIDTH-1];
      unique case (field_sel)
         2'b00: begin
            keep_mask = MaskFull;
            sign_bit  = value_in[IN_WIDTH-1];
         end
         2'b01: begin
            keep_mask = Mask19;
            sign_bit  = value_in[18];
         end
         2'b10: begin
            keep_mask = Mask12;
            sign_bit  = value_in[11];
         end
         default: begin
            keep_mask = Mask9;
            sign_bit  = value_in[8];
         end
      endcase
      fill     = sign_bit & ~zero_ext;
      extended = (padded & keep_mask) | ({OUT_WIDTH{fill}} & ~keep_mask);
      result   = shift2 ? {extended[OUT_WIDTH-3:0], 2'b00} : extended;
   end

   logic [OUT_WIDTH-1:0] data_q [2];
   logic [TAG_WIDTH-1:0] tag_q  [2];
   logic                 wr_ptr_q, rd_ptr_q;
   logic [1:0]           count_q, count_d;
   logic                 push, pop;

   // in_ready depends only on registered occupancy, never on out_ready
   assign in_ready     = (count_q != 2'd2);
   assign out_valid    = (count_q != 2'd0);
   assign push         = in_valid & in_ready;
   assign pop          = out_valid & out_ready;
   assign extended_out = data_q[rd_ptr_q];
   assign tag_out      = tag_q[rd_ptr_q];

   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q  <= 2'd0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            data_q[i] <= '0;
            tag_q[i]  <= '0;
         end
      end else begin
         count_q <= count_d;
         if (push) begin
            data_q[wr_ptr_q] <= result;
            tag_q[wr_ptr_q]  <= tag_in;
            wr_ptr_q         <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
      end
   end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: extension modes, FIFO ordering/backpressure, async reset.
module tb_imm_extend_pipe;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [25:0] value_in;
   logic [1:0]  field_sel;
   logic        zero_ext;
   logic        shift2;
   logic [5:0]  tag_in;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] extended_out;
   logic [5:0]  tag_out;

   int checks;
   int failures;

   imm_extend_pipe #(
      .IN_WIDTH (26),
      .OUT_WIDTH(64),
      .TAG_WIDTH(6)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .value_in    (value_in),
      .field_sel   (field_sel),
      .zero_ext    (zero_ext),
      .shift2      (shift2),
      .tag_in      (tag_in),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .extended_out(extended_out),
      .tag_out     (tag_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: sim time limit reached, required finish before limit");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One-cycle push with out_ready held low
   task automatic push_one(input logic [25:0] v, input logic [1:0] sel, input logic zx,
                           input logic sh, input logic [5:0] t);
      value_in  = v;
      field_sel = sel;
      zero_ext  = zx;
      shift2    = sh;
      tag_in    = t;
      in_valid  = 1'b1;
      tick();
      in_valid  = 1'b0;
   endtask

   task automatic expect_pop(input string name, input logic [63:0] exp_val,
                             input logic [5:0] exp_tag);
      check({name, "_valid"}, 64'(out_valid), 64'd1);
      check({name, "_data"}, extended_out, exp_val);
      check({name, "_tag"}, 64'(tag_out), 64'(exp_tag));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      value_in  = '0;
      field_sel = 2'b00;
      zero_ext  = 1'b0;
      shift2    = 1'b0;
      tag_in    = '0;
      #3;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_data", extended_out, 64'd0);
      check("rst_tag", 64'(tag_out), 64'd0);
      tick();
      reset = 1'b0;
      tick();

      // Extension modes
      push_one(26'h2000000, 2'b00, 1'b0, 1'b0, 6'd5);
      expect_pop("sext26", 64'hFFFF_FFFF_FE00_0000, 6'd5);
      push_one(26'h3FFFFFF, 2'b00, 1'b0, 1'b1, 6'd6);
      expect_pop("sext26_sh2", 64'hFFFF_FFFF_FFFF_FFFC, 6'd6);
      push_one(26'h0000800, 2'b10, 1'b1, 1'b0, 6'd7);
      expect_pop("zext12", 64'h0000_0000_0000_0800, 6'd7);
      push_one(26'h0000800, 2'b10, 1'b0, 1'b0, 6'd8);
      expect_pop("sext12", 64'hFFFF_FFFF_FFFF_F800, 6'd8);
      push_one(26'h3FC0100, 2'b11, 1'b0, 1'b0, 6'd9);
      expect_pop("sext9_upper_ign", 64'hFFFF_FFFF_FFFF_FF00, 6'd9);
      push_one(26'h3F40000, 2'b01, 1'b0, 1'b0, 6'd10);
      expect_pop("sext19", 64'hFFFF_FFFF_FFFC_0000, 6'd10);
      push_one(26'h3FFFFFF, 2'b00, 1'b1, 1'b1, 6'd11);
      expect_pop("zext26_sh2", 64'h0000_0000_0FFF_FFFC, 6'd11);
      push_one(26'h0001234, 2'b00, 1'b0, 1'b1, 6'd12);
      expect_pop("pos26_sh2", 64'h0000_0000_0000_48D0, 6'd12);
      check("empty_after_pops", 64'(out_valid), 64'd0);

      // Backpressure: tags 1,2,3 back-to-back with out_ready low
      value_in  = 26'h0000001;
      field_sel = 2'b00;
      zero_ext  = 1'b0;
      shift2    = 1'b0;
      in_valid  = 1'b1;
      tag_in    = 6'd1;
      tick();
      tag_in    = 6'd2;
      tick();
      check("bp_full_in_ready", 64'(in_ready), 64'd0);
      tag_in    = 6'd3;
      tick();
      check("bp_stall_in_ready", 64'(in_ready), 64'd0);
      check("bp_head_stable", 64'(tag_out), 64'd1);
      out_ready = 1'b1;
      tick();
      check("bp_drain_tag2", 64'(tag_out), 64'd2);
      check("bp_in_ready_reopen", 64'(in_ready), 64'd1);
      tick();
      in_valid  = 1'b0;
      check("bp_drain_tag3", 64'(tag_out), 64'd3);
      check("bp_count1_valid", 64'(out_valid), 64'd1);
      tick();
      check("bp_empty", 64'(out_valid), 64'd0);
      out_ready = 1'b0;

      // Streaming: one result per cycle, occupancy stays at most 1
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tag_in   = 6'(16 + i);
         value_in = 26'(i);
         tick();
         check("stream_valid", 64'(out_valid), 64'd1);
         check("stream_tag", 64'(tag_out), 64'(16 + i));
         check("stream_data", extended_out, 64'(i));
         check("stream_in_ready", 64'(in_ready), 64'd1);
      end
      in_valid = 1'b0;
      tick();
      check("stream_empty", 64'(out_valid), 64'd0);
      out_ready = 1'b0;

      // Async reset with two entries buffered
      push_one(26'h0000011, 2'b00, 1'b0, 1'b0, 6'd20);
      push_one(26'h0000012, 2'b00, 1'b0, 1'b0, 6'd21);
      check("pre_rst_full", 64'(in_ready), 64'd0);
      #2;
      reset = 1'b1;
      #1;
      check("async_rst_valid", 64'(out_valid), 64'd0);
      check("async_rst_in_ready", 64'(in_ready), 64'd1);
      check("async_rst_data", extended_out, 64'd0);
      check("async_rst_tag", 64'(tag_out), 64'd0);
      #2;
      reset = 1'b0;
      tick();
      push_one(26'h0000005, 2'b00, 1'b0, 1'b0, 6'd22);
      expect_pop("post_rst", 64'd5, 6'd22);
      check("post_rst_single", 64'(out_valid), 64'd0);
      tick();
      check("post_rst_no_dup", 64'(out_valid), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
